pop_arbiter: RTL

Drain-side consumer for the transaction-layer datapath. Pulls words out of the two destination FIFOs (D0, D1) using their `D0_can_pop`/`D1_can_pop` status. Grants the two FIFOs round-robin and issues single-cycle `pop_D0`/`pop_D1` strobes. Presents each returned word on a ready/valid output port, checks that bit 4 of the word matches the FIFO it came from, and optionally counts words per destination.

---
 rtl/trans_pkg.sv | 14 +
 rtl/rr_arb2.sv | 35 +++
 rtl/pop_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/trans_pkg.sv
// Shared types and constants for the transaction-layer drain path.
package trans_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2
    } pop_state_t;

    localparam logic DEST_D0  = 1'b0;
    localparam logic DEST_D1  = 1'b1;
    localparam int   DEST_BIT = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_grant only moves when en commits a grant.
module rr_arb2
    import trans_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_idx,
    output logic       last_grant
);

    always_comb begin
        grant_idx = DEST_D0;
        unique case (req)
            2'b01:   grant_idx = DEST_D0;
            2'b10:   grant_idx = DEST_D1;
            2'b11:   grant_idx = (last_grant == DEST_D1) ? DEST_D0 : DEST_D1;
            default: grant_idx = DEST_D0;
        endcase
    end

    always_comb begin
        grant = 2'b00;
        if (|req) grant[grant_idx] = 1'b1;
    end

    // Resets to D1 so D0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   last_grant <= DEST_D1;
        else if (en) last_grant <= grant_idx;
    end

endmodule

// File: rtl/pop_arbiter.sv
// Drains FIFOs D0/D1 one word at a time onto a ready/valid port with a bit-4 route check.
// Optional per-destination word counters are built when POP_COUNT_EN is defined.
module pop_arbiter
    import trans_pkg::*;
#(
    parameter int BITNUMBER = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 D0_can_pop,
    input  logic                 D1_can_pop,
    input  logic [BITNUMBER-1:0] data_D0,
    input  logic [BITNUMBER-1:0] data_D1,
    input  logic                 out_ready,
    output logic                 pop_D0,
    output logic                 pop_D1,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic                 dest_out,
    output logic                 route_err
`ifdef POP_COUNT_EN
    ,
    output logic [CNT_W-1:0]     count_D0,
    output logic [CNT_W-1:0]     count_D1
`endif
);

    generate
        if (BITNUMBER < 5 || CNT_W < 1) begin : g_param_check
            $error("pop_arbiter: BITNUMBER must be >= 5 and CNT_W >= 1");
        end
    endgenerate

    pop_state_t           state, state_nxt;
    logic [1:0]           req, grant;
    logic                 grant_idx, last_grant;
    logic                 start, capture, accept;
    logic                 dest_q;
    logic [BITNUMBER-1:0] cap_word;

    assign req = {D1_can_pop, D0_can_pop};

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .en         (start),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .last_grant (last_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A committed pop always runs to CAPT; can_pop dropping mid-flight is ignored.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start   = (state == IDLE) && (|req) && (!valid_out || out_ready);
        capture = (state == CAPT);
        accept  = valid_out && out_ready;
    end

    assign cap_word = (dest_q == DEST_D1) ? data_D1 : data_D0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_D0 <= 1'b0;
            pop_D1 <= 1'b0;
            dest_q <= DEST_D0;
        end else begin
            pop_D0 <= start & grant[0];
            pop_D1 <= start & grant[1];
            if (start) dest_q <= grant_idx;
        end
    end

    // A fresh capture wins over acceptance clearing valid_out on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            dest_out  <= DEST_D0;
            route_err <= 1'b0;
        end else if (capture) begin
            data_out  <= cap_word;
            valid_out <= 1'b1;
            dest_out  <= dest_q;
            route_err <= cap_word[DEST_BIT] ^ dest_q;
        end else if (accept) begin
            valid_out <= 1'b0;
        end
    end

`ifdef POP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_D0 <= '0;
            count_D1 <= '0;
        end else if (accept) begin
            if (dest_out == DEST_D1) count_D1 <= count_D1 + 1'b1;
            else                     count_D0 <= count_D0 + 1'b1;
        end
    end
`endif

endmodule
